// File: rtl/tick_sequencer.sv
// tick_sequencer: emits a single-cycle tick every P enabled clocks and a dir
// level that sweeps up for SPAN ticks, then down for SPAN ticks, so a
// downstream up/down counter traces a triangle wave. P is reloaded at run
// time through a one-entry valid/ready slot that is applied at the next
// prescaler reload.
// Optional feature: define TICK_SEQ_DWELL_EN to insert a one-period tickless
// dwell at every turnaround; dir then inverts at the dwell exit.
module tick_sequencer #(
  parameter int WIDTH          = 16,
  parameter int SPAN           = 8,
  parameter int DEFAULT_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             period_valid,
  input  logic [WIDTH-1:0] period_data,
  output logic             period_ready,
  output logic             tick,
  output logic             dir
);

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
  localparam logic [7:0]       SPAN_LAST    = 8'(SPAN - 1);

`ifdef TICK_SEQ_DWELL_EN
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DWELL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       span_q, span_d;
  logic             tick_q, tick_d;
  logic             dir_q, dir_d;

  logic             accept;
  logic             load;
  logic             counting;
  logic [WIDTH-1:0] reload_val;

  assign period_ready = !pend_full_q;
  assign tick         = tick_q;
  assign dir          = dir_q;

  // A value offered while the slot is full simply waits for period_ready.
  assign accept     = period_valid && !pend_full_q;
  // A pending period takes effect at the very reload that consumes it.
  assign reload_val = (pend_full_q ? pend_q : period_q) - ONE;

  // Next-state logic: handshake, prescaler step, tick/span bookkeeping, turnaround.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    presc_d     = presc_q;
    period_d    = period_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    span_d      = span_q;
    tick_d      = 1'b0;
    dir_d       = dir_q;
    load        = 1'b0;
    counting    = 1'b0;

    case (state_q)
      S_IDLE: begin
        load     = en;
        counting = en;
        if (en) state_d = S_UP;
      end
      S_UP, S_DOWN: begin
        load     = en && (presc_q == '0);
        counting = en;
      end
`ifdef TICK_SEQ_DWELL_EN
      S_DWELL: begin
        load = en && (presc_q == '0);
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // In IDLE a pending period is taken immediately; otherwise at a reload.
    if (pend_full_q && (load || state_q == S_IDLE)) begin
      period_d    = pend_q;
      pend_full_d = 1'b0;
    end

    // The slot only accepts while empty, so this never collides with the apply above.
    if (accept) begin
      pend_d      = (period_data == '0) ? ONE : period_data;
      pend_full_d = 1'b1;
    end

    if (load) begin
      presc_d = reload_val;
    end else if (en) begin
      presc_d = presc_q - ONE;
    end

    // The prescaler arriving at zero in a run state is the tick.
    if (counting && presc_d == '0) begin
      tick_d = 1'b1;
      if (span_q == SPAN_LAST) begin
        span_d = '0;
`ifdef TICK_SEQ_DWELL_EN
        state_d = S_DWELL;
`else
        state_d = (state_q == S_DOWN) ? S_UP : S_DOWN;
`endif
      end else begin
        span_d = span_q + 8'd1;
      end
    end

`ifdef TICK_SEQ_DWELL_EN
    // Dwell lasts one full period; leave toward the opposite direction.
    if (state_q == S_DWELL && en && presc_d == '0) begin
      state_d = dir_q ? S_DOWN : S_UP;
      dir_d   = !dir_q;
    end
`else
    // The state has already turned while the last tick is shown, so dir
    // follows it one cycle later and that tick keeps the old direction.
    if (tick_q) dir_d = (state_q != S_DOWN);
`endif
  end

  // State and datapath registers; reset also discards any pending period.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      period_q    <= RESET_PERIOD;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      span_q      <= '0;
      tick_q      <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      period_q    <= period_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      span_q      <= span_d;
      tick_q      <= tick_d;
      dir_q       <= dir_d;
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Self-checking bench for tick_sequencer. The stimulus side steps a reference
// model (ticks every P enabled cycles, dir derived from the tick index) and
// queues expected ticks and per-cycle period_ready values; a monitor on the
// falling edge pops and compares them against the DUT.
// Build with TICK_SEQ_DWELL_EN defined to exercise the dwell variant.
module tb_tick_sequencer;

  localparam int WIDTH          = 8;
  localparam int SPAN           = 3;
  localparam int DEFAULT_PERIOD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             period_valid;
  logic [WIDTH-1:0] period_data;
  logic             period_ready;
  logic             tick;
  logic             dir;

  tick_sequencer #(
    .WIDTH(WIDTH),
    .SPAN(SPAN),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .period_valid(period_valid),
    .period_data(period_data),
    .period_ready(period_ready),
    .tick(tick),
    .dir(dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit dir; } tick_exp_t;
  typedef struct { int cyc; bit ready; bit idle; } cyc_exp_t;

  tick_exp_t tick_q[$];
  cyc_exp_t  cyc_q[$];
  tick_exp_t log_q[$];

  int checks = 0;
  int errors = 0;

  // Expected tick offsets from c0 and their dir for P=4, SPAN=3, en held high.
  int exp_off [8] = '{4, 8, 12, 16, 20, 24, 28, 32};
  int exp_dir [8] = '{1, 1, 1, 0, 0, 0, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: counts enabled cycles within each period interval.
  bit m_run;
  bit m_dwell;
  int m_cnt;
  int m_p;
  int m_pend;
  int m_ntick;

  function automatic void model_edge(input bit r, input bit e, input bit v, input int d);
    bit acc;
    int nc;
    nc = cyc + 1;
    if (r) begin
      m_run   = 1'b0;
      m_dwell = 1'b0;
      m_cnt   = 0;
      m_p     = DEFAULT_PERIOD;
      m_pend  = 0;
      m_ntick = 0;
      cyc_q.push_back('{nc, 1'b1, 1'b1});
      return;
    end
    acc = v && (m_pend == 0);
    if (!m_run) begin
      if (m_pend != 0) begin
        m_p    = m_pend;
        m_pend = 0;
      end
      if (e) m_run = 1'b1;
    end
    if (m_run && e) begin
      if (m_cnt == 0 && m_pend != 0) begin
        m_p    = m_pend;
        m_pend = 0;
      end
      m_cnt++;
      if (m_cnt >= m_p) begin
        m_cnt = 0;
        if (m_dwell) begin
          m_dwell = 1'b0;
        end else begin
          tick_q.push_back('{nc, bit'(((m_ntick / SPAN) % 2) == 0)});
          m_ntick++;
`ifdef TICK_SEQ_DWELL_EN
          if (m_ntick % SPAN == 0) m_dwell = 1'b1;
`endif
        end
      end
    end
    if (acc) m_pend = (d == 0) ? 1 : d;
    cyc_q.push_back('{nc, bit'(m_pend == 0), bit'(!m_run)});
  endfunction

  task automatic drive(input bit r, input bit e, input bit v, input int d);
    rst          = r;
    en           = e;
    period_valid = v;
    period_data  = d[WIDTH-1:0];
    model_edge(r, e, v, d);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    cyc_exp_t  ce;
    tick_exp_t te;
    while (cyc_q.size() > 0 && cyc_q[0].cyc < cyc) void'(cyc_q.pop_front());
    if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
      ce = cyc_q.pop_front();
      check("period_ready", 32'(period_ready), 32'(ce.ready));
      if (ce.idle) begin
        check("idle_dir", 32'(dir), 32'd1);
        check("idle_tick", 32'(tick), 32'd0);
      end
    end
    if (tick === 1'b1) begin
      log_q.push_back('{cyc, bit'(dir)});
      if (tick_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick at cycle %0d: got tick=1 expected 0", cyc);
      end else begin
        te = tick_q.pop_front();
        check("tick_cycle", cyc, te.cyc);
        check("tick_dir", 32'(dir), 32'(te.dir));
      end
    end else if (tick_q.size() > 0 && tick_q[0].cyc <= cyc) begin
      te = tick_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_tick at cycle %0d: got tick=%b expected 1 (due cycle %0d)", cyc, tick, te.cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  c0;
    int  guard;
    bit  r_r, r_e, r_v;
    int  r_d;

    // Reset held for two cycles with en high.
    drive(1'b1, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b0, 0);

    // Basic period with en held high.
    c0 = cyc;
    log_q.delete();
    repeat (36) drive(1'b0, 1'b1, 1'b0, 0);
`ifndef TICK_SEQ_DWELL_EN
    check("basic_tick_count", 32'(log_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("basic_offset", log_q[i].cyc - c0, exp_off[i]);
      check("basic_dir", 32'(log_q[i].dir), exp_dir[i]);
    end
`endif

    // Pause for 5 cycles between the first and second tick.
    drive(1'b1, 1'b0, 1'b0, 0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 0);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 0);

    // Reload to P=2 at c5, then period_data=0 (stored as 1).
    drive(1'b1, 1'b0, 1'b0, 0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 2);
    repeat (15) drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
    repeat (12) drive(1'b0, 1'b1, 1'b0, 0);

    // Backpressure: 3 is taken, 5 is held until the slot empties.
    drive(1'b1, 1'b0, 1'b0, 0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 3);
    guard = 0;
    while (m_pend != 0 && guard < 50) begin
      drive(1'b0, 1'b1, 1'b1, 5);
      guard++;
    end
    if (guard >= 50) check("backpressure_accept_timeout", guard, 0);
    drive(1'b0, 1'b1, 1'b1, 5);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 0);

    // Reset in the middle of a run with a period offered in the same cycle.
    repeat (7) drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 2);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 0);

    // Randomised traffic.
    drive(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 599) == 0);
      r_e = ($urandom_range(0, 9) < 8);
      r_v = ($urandom_range(0, 9) < 2);
      r_d = int'($urandom_range(0, 5));
      drive(r_r, r_e, r_v, r_d);
    end

    // Drain with en low and confirm every expected tick was seen.
    repeat (10) drive(1'b0, 1'b0, 1'b0, 0);
    check("tick_queue_drained", tick_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
